// File: rtl/ahb_decoder_mux.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : ahb_decoder_mux                                                 |
// | Purpose  : AHB-Lite address decoder, response multiplexer and default     |
// |            slave. Optional error-address capture: AHB_DECODER_ERR_CAPTURE_EN|
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module ahb_decoder_mux #(
    parameter int                       NUM_SLAVES = 10,
    parameter int                       DATA_W     = 32,
    parameter logic [8*NUM_SLAVES-1:0]  SLV_BASE   = {8'h58, 8'h57, 8'h56, 8'h55, 8'h54,
                                                      8'h53, 8'h52, 8'h51, 8'h50, 8'h00},
    parameter logic [8*NUM_SLAVES-1:0]  SLV_MASK   = {NUM_SLAVES{8'hFF}}
) (
    input  logic                         HCLK,
    input  logic                         HRESETn,
    input  logic [31:0]                  HADDR,
    input  logic [1:0]                   HTRANS,
    output logic [NUM_SLAVES-1:0]        HSEL_S,
    output logic                         HSEL_NOMAP,
    input  logic [NUM_SLAVES*DATA_W-1:0] HRDATA_S,
    input  logic [NUM_SLAVES-1:0]        HREADYOUT_S,
    input  logic [NUM_SLAVES-1:0]        HRESP_S,
    output logic [DATA_W-1:0]            HRDATA,
    output logic                         HREADY,
    output logic                         HRESP,
`ifdef AHB_DECODER_ERR_CAPTURE_EN
    output logic [31:0]                  ERR_ADDR,
    output logic                         ERR_VALID,
    input  logic                         ERR_CLR,
`endif
    output logic [3:0]                   MUX_SEL
);

    localparam logic [3:0] c_nomap_idx = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ERR1 = 2'd1,
        ST_ERR2 = 2'd2
    } dflt_state_t;

    logic [NUM_SLAVES-1:0] w_match;
    logic [NUM_SLAVES-1:0] w_sel;
    logic [3:0]            w_win_idx;
    logic                  w_hit;
    logic [3:0]            r_mux_sel;
    dflt_state_t           r_state;
    dflt_state_t           w_state_nxt;
    logic                  w_def_ready;
    logic                  w_def_resp;
    logic                  w_err_start;
    logic                  w_unused;

    // Only the top address byte and HTRANS[1] take part in decoding.
    assign w_unused = &{1'b0, HTRANS[0], HADDR[23:0]};

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SLAVES; gi++) begin : g_match
            assign w_match[gi] = ((HADDR[31:24] & SLV_MASK[8*gi +: 8]) == SLV_BASE[8*gi +: 8]);
        end
    endgenerate

    // Priority pick: the lowest matching index wins, keeping HSEL_S one-hot
    // even when regions overlap.
    always_comb begin
        w_sel     = '0;
        w_win_idx = c_nomap_idx;
        w_hit     = 1'b0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (w_match[i] && !w_hit) begin
                w_hit     = 1'b1;
                w_sel[i]  = 1'b1;
                w_win_idx = 4'(i);
            end
        end
    end

    assign HSEL_S     = w_sel;
    assign HSEL_NOMAP = ~w_hit;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_mux_sel <= c_nomap_idx;
        end else if (HREADY) begin
            r_mux_sel <= w_win_idx;
        end
    end

    assign MUX_SEL = r_mux_sel;

    // Any select that names no real slave falls through to the default slave.
    always_comb begin
        HRDATA = '0;
        HREADY = w_def_ready;
        HRESP  = w_def_resp;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (r_mux_sel == 4'(i)) begin
                HRDATA = HRDATA_S[i*DATA_W +: DATA_W];
                HREADY = HREADYOUT_S[i];
                HRESP  = HRESP_S[i];
            end
        end
    end

    assign w_err_start = HREADY & HSEL_NOMAP & HTRANS[1];

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_def_ready = 1'b1;
        w_def_resp  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_err_start) begin
                    w_state_nxt = ST_ERR1;
                end
            end
            ST_ERR1: begin
                w_def_ready = 1'b0;
                w_def_resp  = 1'b1;
                w_state_nxt = ST_ERR2;
            end
            ST_ERR2: begin
                w_def_resp  = 1'b1;
                w_state_nxt = w_err_start ? ST_ERR1 : ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

`ifdef AHB_DECODER_ERR_CAPTURE_EN
    logic        w_err_enter;
    logic [31:0] r_err_addr;
    logic        r_err_valid;

    assign w_err_enter = w_err_start & (r_state != ST_ERR1);

    // First error is sticky; a new error beats a simultaneous clear.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_err_addr  <= '0;
            r_err_valid <= 1'b0;
        end else if (w_err_enter) begin
            if (!r_err_valid) begin
                r_err_addr <= HADDR;
            end
            r_err_valid <= 1'b1;
        end else if (ERR_CLR) begin
            r_err_valid <= 1'b0;
        end
    end

    assign ERR_ADDR  = r_err_addr;
    assign ERR_VALID = r_err_valid;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ahb_decoder_mux.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_ahb_decoder_mux                                              |
// | Purpose  : Self-checking bench for ahb_decoder_mux: decode table, directed |
// |            multi-cycle sequences and randomized traffic vs. a bus model.   |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_ahb_decoder_mux;

    localparam logic [1:0] IDLE_T = 2'b00, BUSY_T = 2'b01, NONSEQ_T = 2'b10, SEQ_T = 2'b11;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic [9:0]  HSEL_S;
    logic        HSEL_NOMAP;
    logic [319:0] HRDATA_S;
    logic [9:0]  HREADYOUT_S;
    logic [9:0]  HRESP_S;
    logic [31:0] HRDATA;
    logic        HREADY;
    logic        HRESP;
    logic [3:0]  MUX_SEL;

    logic [1:0]  ov_hsel;
    logic        ov_nomap;
    logic [31:0] ov_hrdata;
    logic        ov_hready;
    logic        ov_hresp;
    logic [3:0]  ov_mux_sel;

`ifdef AHB_DECODER_ERR_CAPTURE_EN
    logic [31:0] ERR_ADDR;
    logic        ERR_VALID;
    logic        ERR_CLR;
    logic [31:0] ov_err_addr;
    logic        ov_err_valid;
`endif

    always #5 HCLK = ~HCLK;

    ahb_decoder_mux dut (
        .HCLK        (HCLK),
        .HRESETn     (HRESETn),
        .HADDR       (HADDR),
        .HTRANS      (HTRANS),
        .HSEL_S      (HSEL_S),
        .HSEL_NOMAP  (HSEL_NOMAP),
        .HRDATA_S    (HRDATA_S),
        .HREADYOUT_S (HREADYOUT_S),
        .HRESP_S     (HRESP_S),
        .HRDATA      (HRDATA),
        .HREADY      (HREADY),
        .HRESP       (HRESP),
`ifdef AHB_DECODER_ERR_CAPTURE_EN
        .ERR_ADDR    (ERR_ADDR),
        .ERR_VALID   (ERR_VALID),
        .ERR_CLR     (ERR_CLR),
`endif
        .MUX_SEL     (MUX_SEL)
    );

    // Overlapping map: slave0 covers 0x5X, slave1 only 0x51.
    ahb_decoder_mux #(
        .NUM_SLAVES (2),
        .DATA_W     (32),
        .SLV_BASE   ({8'h51, 8'h50}),
        .SLV_MASK   ({8'hFF, 8'hF0})
    ) dut_ov (
        .HCLK        (HCLK),
        .HRESETn     (HRESETn),
        .HADDR       (HADDR),
        .HTRANS      (HTRANS),
        .HSEL_S      (ov_hsel),
        .HSEL_NOMAP  (ov_nomap),
        .HRDATA_S    (64'd0),
        .HREADYOUT_S (2'b11),
        .HRESP_S     (2'b00),
        .HRDATA      (ov_hrdata),
        .HREADY      (ov_hready),
        .HRESP       (ov_hresp),
`ifdef AHB_DECODER_ERR_CAPTURE_EN
        .ERR_ADDR    (ov_err_addr),
        .ERR_VALID   (ov_err_valid),
        .ERR_CLR     (1'b0),
`endif
        .MUX_SEL     (ov_mux_sel)
    );

    int checks = 0;
    int errors = 0;

    // Bus model: owner of the current data phase (-1 = default slave) and how
    // many error-response cycles the default slave has delivered (0, 1 or 2).
    int m_owner = -1;
    int m_phase = 0;
    byte unsigned m_base [10] = '{8'h00, 8'h50, 8'h51, 8'h52, 8'h53,
                                  8'h54, 8'h55, 8'h56, 8'h57, 8'h58};

    typedef struct {
        logic [31:0] addr;
        logic [1:0]  trans;
        logic [9:0]  exp_sel;
        logic        exp_nomap;
    } dec_vec_t;

    dec_vec_t dvec [9];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int ref_decode(input logic [31:0] a);
        for (int i = 0; i < 10; i++) begin
            if (a[31:24] == m_base[i]) return i;
        end
        return -1;
    endfunction

    function automatic logic m_ready();
        if (m_owner < 0) return (m_phase != 1);
        return HREADYOUT_S[m_owner];
    endfunction

    task automatic check_all();
        int          win;
        logic [9:0]  esel;
        logic        erdy;
        logic        eresp;
        logic [31:0] edata;
        logic [3:0]  emux;
        win  = ref_decode(HADDR);
        esel = (win < 0) ? 10'd0 : (10'd1 << win);
        if (m_owner < 0) begin
            emux  = 4'hF;
            erdy  = (m_phase != 1);
            eresp = (m_phase != 0);
            edata = 32'd0;
        end else begin
            emux  = 4'(m_owner);
            erdy  = HREADYOUT_S[m_owner];
            eresp = HRESP_S[m_owner];
            edata = HRDATA_S[m_owner*32 +: 32];
        end
        chk("hsel_s",     HSEL_S,     esel);
        chk("hsel_nomap", HSEL_NOMAP, (win < 0));
        chk("mux_sel",    MUX_SEL,    emux);
        chk("hready",     HREADY,     erdy);
        chk("hresp",      HRESP,      eresp);
        chk("hrdata",     HRDATA,     edata);
    endtask

    // Advance one clock edge and update the model from the pre-edge inputs.
    task automatic tick();
        logic rdy;
        int   win;
        rdy = m_ready();
        win = ref_decode(HADDR);
        @(posedge HCLK);
        if (!HRESETn) begin
            m_owner = -1;
            m_phase = 0;
        end else if (rdy) begin
            m_owner = win;
            m_phase = (win < 0 && HTRANS[1]) ? 1 : 0;
        end else if (m_owner < 0 && m_phase == 1) begin
            m_phase = 2;
        end
    endtask

    task automatic drive(input logic [31:0] a, input logic [1:0] t, input logic [9:0] hro);
        @(negedge HCLK);
        HADDR       = a;
        HTRANS      = t;
        HREADYOUT_S = hro;
        #1;
        check_all();
    endtask

    function automatic logic [7:0] rand_top();
        case ($urandom_range(0, 3))
            0:       return 8'h50 + 8'($urandom_range(0, 9));
            1:       return 8'h00;
            2:       return 8'h70;
            default: return 8'($urandom);
        endcase
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        dvec[0] = '{32'h5300_0010, NONSEQ_T, 10'h010, 1'b0};
        dvec[1] = '{32'h0000_0000, IDLE_T,   10'h001, 1'b0};
        dvec[2] = '{32'h5000_1234, SEQ_T,    10'h002, 1'b0};
        dvec[3] = '{32'h58FF_FFFF, BUSY_T,   10'h200, 1'b0};
        dvec[4] = '{32'h5500_0000, NONSEQ_T, 10'h040, 1'b0};
        dvec[5] = '{32'h5700_0000, SEQ_T,    10'h100, 1'b0};
        dvec[6] = '{32'h5900_0000, IDLE_T,   10'h000, 1'b1};
        dvec[7] = '{32'h4FFF_FFFF, BUSY_T,   10'h000, 1'b1};
        dvec[8] = '{32'hFF00_0000, IDLE_T,   10'h000, 1'b1};

        HRESETn     = 1'b0;
        HADDR       = 32'd0;
        HTRANS      = IDLE_T;
        HREADYOUT_S = '1;
        HRESP_S     = '0;
        for (int i = 0; i < 10; i++) HRDATA_S[i*32 +: 32] = 32'hCAFE_0000 | i;
`ifdef AHB_DECODER_ERR_CAPTURE_EN
        ERR_CLR = 1'b0;
`endif

        // Reset state, while held and in the first cycle after release
        repeat (3) tick();
        @(negedge HCLK);
        #1;
        chk("rst_hready",  HREADY,  1'b1);
        chk("rst_hresp",   HRESP,   1'b0);
        chk("rst_hrdata",  HRDATA,  32'd0);
        chk("rst_mux_sel", MUX_SEL, 4'hF);
        tick();
        @(negedge HCLK);
        HRESETn = 1'b1;
        #1;
        check_all();
        chk("rel_mux_sel", MUX_SEL, 4'hF);
        tick();

        // Decode table
        for (int v = 0; v < 9; v++) begin
            drive(dvec[v].addr, dvec[v].trans, '1);
            chk($sformatf("dec%0d_sel", v),   HSEL_S,     dvec[v].exp_sel);
            chk($sformatf("dec%0d_nomap", v), HSEL_NOMAP, dvec[v].exp_nomap);
            tick();
        end

        // Overlapping regions resolve to the lowest index
        drive(32'h5100_0000, IDLE_T, '1);
        chk("ov_51_sel", ov_hsel, 2'b01);
        tick();
        drive(32'h5200_0000, IDLE_T, '1);
        chk("ov_52_sel", ov_hsel, 2'b01);
        tick();
        drive(32'h6100_0000, IDLE_T, '1);
        chk("ov_61_nomap", ov_nomap, 1'b1);
        chk("ov_61_sel",   ov_hsel,  2'b00);
        tick();

        // Slave 4 read with one wait state
        drive(32'h5300_0010, NONSEQ_T, '1);
        chk("s4_hsel", HSEL_S, 10'b00_0001_0000);
        tick();
        drive(32'h0000_0000, IDLE_T, ~10'h010);
        chk("s4_mux_sel", MUX_SEL, 4'd4);
        chk("s4_wait",    HREADY,  1'b0);
        tick();
        drive(32'h0000_0000, IDLE_T, '1);
        chk("s4_done",  HREADY, 1'b1);
        chk("s4_rdata", HRDATA, 32'hCAFE_0004);
        tick();

        // Unmapped NONSEQ, then a back-to-back second one
        drive(32'h7000_0000, NONSEQ_T, '1);
        chk("um_nomap", HSEL_NOMAP, 1'b1);
        tick();
        drive(32'h7000_0000, NONSEQ_T, '1);
        chk("um_e1_rdy", HREADY, 1'b0);
        chk("um_e1_rsp", HRESP,  1'b1);
        tick();
        drive(32'h7000_0000, NONSEQ_T, '1);
        chk("um_e2_rdy", HREADY, 1'b1);
        chk("um_e2_rsp", HRESP,  1'b1);
        tick();
        drive(32'h0000_0000, IDLE_T, '1);
        chk("b2b_e1_rdy", HREADY, 1'b0);
        chk("b2b_e1_rsp", HRESP,  1'b1);
        tick();
        drive(32'h0000_0000, IDLE_T, '1);
        chk("b2b_e2_rdy", HREADY, 1'b1);
        chk("b2b_e2_rsp", HRESP,  1'b1);
        tick();
        drive(32'h0000_0000, IDLE_T, '1);
        chk("b2b_end_rsp", HRESP, 1'b0);
        tick();

        // IDLE and BUSY to unmapped space: zero-wait OKAY
        drive(32'h7000_0000, IDLE_T, '1);
        tick();
        drive(32'h7000_0000, BUSY_T, '1);
        chk("idle_um_rdy", HREADY,  1'b1);
        chk("idle_um_rsp", HRESP,   1'b0);
        chk("idle_um_mux", MUX_SEL, 4'hF);
        tick();
        drive(32'h0000_0000, IDLE_T, '1);
        chk("busy_um_rsp", HRESP, 1'b0);
        tick();

        // Reset asserted during ERR1
        drive(32'h7000_0000, NONSEQ_T, '1);
        tick();
        drive(32'h0000_0000, IDLE_T, '1);
        chk("rerr_e1_rdy", HREADY, 1'b0);
        HRESETn = 1'b0;
        m_owner = -1;
        m_phase = 0;
        #1;
        chk("rerr_rdy", HREADY,  1'b1);
        chk("rerr_rsp", HRESP,   1'b0);
        chk("rerr_mux", MUX_SEL, 4'hF);
        tick();
        @(negedge HCLK);
        HRESETn = 1'b1;
        #1;
        check_all();
        tick();

`ifdef AHB_DECODER_ERR_CAPTURE_EN
        drive(32'h0000_0000, IDLE_T, '1);
        chk("cap_rst_valid", ERR_VALID, 1'b0);
        chk("cap_rst_addr",  ERR_ADDR,  32'd0);
        tick();
        drive(32'h7000_0004, NONSEQ_T, '1);
        tick();
        drive(32'h0000_0000, IDLE_T, '1);
        chk("cap1_valid", ERR_VALID, 1'b1);
        chk("cap1_addr",  ERR_ADDR,  32'h7000_0004);
        tick();
        drive(32'h7100_0000, NONSEQ_T, '1);
        tick();
        drive(32'h0000_0000, IDLE_T, '1);
        chk("cap2_sticky", ERR_ADDR, 32'h7000_0004);
        tick();
        drive(32'h0000_0000, IDLE_T, '1);
        ERR_CLR = 1'b1;
        tick();
        drive(32'h7200_0000, NONSEQ_T, '1);
        ERR_CLR = 1'b0;
        chk("clr_valid", ERR_VALID, 1'b0);
        ERR_CLR = 1'b1;
        tick();
        drive(32'h0000_0000, IDLE_T, '1);
        ERR_CLR = 1'b0;
        chk("clr_vs_err_valid", ERR_VALID, 1'b1);
        chk("clr_vs_err_addr",  ERR_ADDR,  32'h7200_0000);
        tick();
        drive(32'h0000_0000, IDLE_T, '1);
        tick();
`endif

        // Randomized traffic, including occasional asynchronous resets
        for (int n = 0; n < 400; n++) begin
            @(negedge HCLK);
            HRESETn = ($urandom_range(0, 63) != 0);
            if (!HRESETn) begin
                m_owner = -1;
                m_phase = 0;
            end
            HADDR  = {rand_top(), 24'($urandom)};
            HTRANS = 2'($urandom);
            for (int i = 0; i < 10; i++) begin
                HREADYOUT_S[i]        = ($urandom_range(0, 3) != 0);
                HRESP_S[i]            = 1'($urandom);
                HRDATA_S[i*32 +: 32]  = $urandom;
            end
            #1;
            check_all();
            tick();
        end

        @(negedge HCLK);
        HRESETn = 1'b1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ahb_decoder_mux.md
Name: ahb_decoder_mux

Overview:
- Parametrised AHB-Lite address decoder plus slave-to-master response multiplexer, with an integrated default slave.
- Sits between the single bus master and up to 15 slaves.
- Address phase: combinationally generates one-hot HSEL from HADDR[31:24] using per-slave base/mask parameters.
- Data phase: registers the select so HRDATA, HREADY and HRESP are steered from the slave owning the current data phase.
- Unmapped NONSEQ/SEQ transfers get a protocol-correct two-cycle ERROR response from the default slave.

Parameters:
- NUM_SLAVES, 10, number of mapped slaves; legal range 1..15.
- DATA_W, 32, HRDATA width.
- SLV_BASE, {8'h58,8'h57,8'h56,8'h55,8'h54,8'h53,8'h52,8'h51,8'h50,8'h00}, packed 8 bits per slave; slave i occupies bits [8i+7:8i]; base compared with HADDR[31:24].
- SLV_MASK, all 8'hFF, packed 8 bits per slave; slave i matches when (HADDR[31:24] & mask_i) == base_i.

Ports:
- HCLK  in  1  bus clock.
- HRESETn  in  1  asynchronous active-low reset.
- HADDR  in  32  master address.
- HTRANS  in  2  master transfer type.
- HSEL_S  out  NUM_SLAVES  one-hot address-phase select, bit i = slave i.
- HSEL_NOMAP  out  1  address-phase select of the default slave.
- HRDATA_S  in  NUM_SLAVES*DATA_W  packed slave read data.
- HREADYOUT_S  in  NUM_SLAVES  per-slave ready.
- HRESP_S  in  NUM_SLAVES  per-slave response.
- HRDATA  out  DATA_W  muxed read data to master.
- HREADY  out  1  muxed ready; also fed back to all slaves.
- HRESP  out  1  muxed response.
- MUX_SEL  out  4  registered data-phase select; slave index, or 4'hF = default slave.

Behaviour:
- Decode (combinational):
  - Lowest index i whose masked compare matches wins. HSEL_S is strictly one-hot even when regions overlap.
  - No match: HSEL_NOMAP=1, HSEL_S=0.
  - Exactly one of HSEL_S/HSEL_NOMAP is high at all times, independent of HTRANS.
- Data-phase select register:
  - On a rising HCLK edge with HREADY=1, MUX_SEL <= index of address-phase winner (4'hF if none).
  - With HREADY=0, MUX_SEL holds.
  - Reset value: 4'hF.
- Output mux:
  - MUX_SEL=i: HRDATA = HRDATA_S[i], HREADY = HREADYOUT_S[i], HRESP = HRESP_S[i].
  - MUX_SEL=4'hF: outputs come from the default slave.
  - Any MUX_SEL value >= NUM_SLAVES other than 4'hF: treated as 4'hF.
- Default slave:
  - HRDATA is always 0.
  - States:
    - IDLE: HREADYOUT=1, HRESP=0.
    - ERR1: HREADYOUT=0, HRESP=1.
    - ERR2: HREADYOUT=1, HRESP=1.
  - Transitions:
    - IDLE -> ERR1 when HREADY=1 & HSEL_NOMAP=1 & HTRANS[1]=1 (NONSEQ/SEQ).
    - ERR1 -> ERR2 unconditionally.
    - ERR2 -> ERR1 if the same condition holds again (back-to-back unmapped); else ERR2 -> IDLE.
  - IDLE/BUSY transfers to unmapped space complete zero-wait with OKAY.
- Reset values: state=IDLE, MUX_SEL=4'hF. Therefore HREADY=1, HRESP=0, HRDATA=0 while HRESETn=0 and in the first cycle after release.
- Reset asserted mid-transfer (including in ERR1/ERR2) immediately forces the reset values; no response completion is owed.
- Latency:
  - Decode: 0 cycles.
  - Mapped response: slave latency + 0.
  - Unmapped error: exactly 2 data-phase cycles.

Optional Feature:
- Macro: AHB_DECODER_ERR_CAPTURE_EN.
- When defined, adds the following ports:
  - ERR_ADDR  out  32
  - ERR_VALID  out  1
  - ERR_CLR  in  1
- On each IDLE->ERR1 or ERR2->ERR1 transition, the faulting HADDR is captured into ERR_ADDR, but only when ERR_VALID=0 (first error sticky). ERR_VALID is then set.
- ERR_CLR=1 clears ERR_VALID on the next edge. If a new error and ERR_CLR occur in the same cycle, the new error wins: capture and ERR_VALID=1.
- Reset: ERR_ADDR=0, ERR_VALID=0.
- When not defined: ports absent; no registers added; all other behaviour identical.

Test Plan:
- Reset with HRESETn=0, then release -> HREADY=1, HRESP=0, HRDATA=0, MUX_SEL=4'hF.
- NONSEQ read HADDR=32'h5300_0010, slave 4 returns 32'hCAFE_0004 with one wait state -> HSEL_S=10'b00_0001_0000; MUX_SEL=4 after the address edge; HREADY low 1 cycle; HRDATA=32'hCAFE_0004 on completion.
- NONSEQ HADDR=32'h7000_0000 -> HSEL_NOMAP=1; data phase HREADY=0/HRESP=1, then HREADY=1/HRESP=1. Back-to-back second unmapped NONSEQ repeats ERR1/ERR2 with no IDLE cycle between.
- IDLE HTRANS=2'b00 at HADDR=32'h7000_0000 -> zero-wait OKAY; state stays IDLE.
- Overlap: slave0 base 8'h50 mask 8'hF0, slave1 base 8'h51 mask 8'hFF, HADDR=32'h5100_0000 -> slave0 selected (lowest index wins).
- HRESETn asserted during ERR1 -> HREADY=1, HRESP=0 immediately. With AHB_DECODER_ERR_CAPTURE_EN: after error at 32'h7000_0004, ERR_ADDR=32'h7000_0004 and ERR_VALID=1; a second error does not overwrite; ERR_CLR clears ERR_VALID.
